// File: rtl/note_recorder_pkg.sv
// Shared types and helpers for the note recorder: state encoding, symbol layout,
// and the key <-> note code conversions used on both the record and replay paths.
package note_recorder_pkg;

   localparam int SYM_W  = 6;
   localparam int NOTE_W = 3;
   localparam int OCT_W  = 3;
   localparam int KEY_W  = 7;
   localparam int CNT_W  = 7;

   localparam logic [NOTE_W-1:0] NOTE_REST = 3'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REC,
      S_PLAY_RD,
      S_PLAY_RUN
   } state_t;

   typedef struct packed {
      logic [OCT_W-1:0]  oct;
      logic [NOTE_W-1:0] note;
   } sym_t;

   // Higher key bits are lower note numbers and win when several keys are held.
   function automatic logic [NOTE_W-1:0] key_to_note(input logic [KEY_W-1:0] key);
      key_to_note = NOTE_REST;
      for (int i = 0; i < KEY_W; i++)
         if (key[i]) key_to_note = NOTE_W'(KEY_W - i);
   endfunction

   function automatic logic [KEY_W-1:0] note_to_key(input logic [NOTE_W-1:0] note);
      note_to_key = '0;
      if (note != NOTE_REST) note_to_key = 7'b1000000 >> (note - 3'd1);
   endfunction

endpackage

// File: rtl/note_recorder_if.sv
// Performance/replay signal bundle between the organ top and the note recorder.
interface note_recorder_if;
   import note_recorder_pkg::*;

   logic               rec_sw;
   logic               play_btn;
   logic [KEY_W-1:0]   key_in;
   logic [OCT_W-1:0]   oct_in;
   logic [KEY_W-1:0]   key_out;
   logic [OCT_W-1:0]   oct_out;
   logic               recording;
   logic               playing;
   logic               full;
   logic [CNT_W-1:0]   evt_count;

   modport master (
      output rec_sw, play_btn, key_in, oct_in,
      input  key_out, oct_out, recording, playing, full, evt_count
   );

   modport slave (
      input  rec_sw, play_btn, key_in, oct_in,
      output key_out, oct_out, recording, playing, full, evt_count
   );

endinterface

// File: rtl/note_recorder_rec_ram.sv
// Event buffer: one write port, one registered read port, contents not reset.
module rec_ram #(
   parameter int DEPTH = 64,
   parameter int W     = 14
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/note_recorder.sv
// Records live keys/octave as run-length timed events and replays them with the
// original timing on key_out/oct_out.
module note_recorder
   import note_recorder_pkg::*;
#(
   parameter int TICK_DIV = 500_000,
   parameter int DEPTH    = 64,
   parameter int DUR_W    = 8
) (
   input  logic          clk,
   input  logic          rst,
   note_recorder_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = SYM_W + DUR_W;
   localparam int TW = $clog2(TICK_DIV + 1);

   localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [DUR_W-1:0] DUR_MAX   = '1;
   localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   // input synchronizers and edge detectors
   logic [1:0]       rec_sy, play_sy;
   logic             rec_d, play_d;
   logic [KEY_W-1:0] key_s1, key_s2;
   logic [OCT_W-1:0] oct_s1, oct_s2;
   logic             rec_s, rec_rise, rec_fall, play_rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         rec_sy  <= '0;
         play_sy <= '0;
         rec_d   <= 1'b0;
         play_d  <= 1'b0;
         key_s1  <= '0;
         key_s2  <= '0;
         oct_s1  <= '0;
         oct_s2  <= '0;
      end else begin
         rec_sy  <= {rec_sy[0], bus.rec_sw};
         play_sy <= {play_sy[0], bus.play_btn};
         rec_d   <= rec_sy[1];
         play_d  <= play_sy[1];
         key_s1  <= bus.key_in;
         key_s2  <= key_s1;
         oct_s1  <= bus.oct_in;
         oct_s2  <= oct_s1;
      end
   end

   assign rec_s     = rec_sy[1];
   assign rec_rise  = rec_sy[1] & ~rec_d;
   assign rec_fall  = ~rec_sy[1] & rec_d;
   assign play_rise = play_sy[1] & ~play_d;

   // free-running timing tick
   logic [TW-1:0] tcnt;
   logic          tick;

   always_ff @(posedge clk) begin
      if (rst || tick) tcnt <= '0;
      else             tcnt <= tcnt + TW'(1);
   end

   assign tick = (tcnt == TICK_LAST);

   // FSM state and datapath registers
   state_t           state;
   sym_t             cur, held, rd_sym;
   logic [DUR_W-1:0] dur, remaining, rd_dur;
   logic [CNT_W-1:0] evt_count, rd_ptr, rd_nxt;
   logic             full;
   logic [KEY_W-1:0] key_out_r;
   logic [OCT_W-1:0] oct_out_r;

   logic             extend, wr_en;
   logic [AW-1:0]    raddr;
   logic [EW-1:0]    rdata;

   assign cur    = '{oct: oct_s2, note: key_to_note(key_s2)};
   assign extend = (cur == held) && (dur != DUR_MAX);
   assign rd_nxt = rd_ptr + CNT_ONE;
   assign rd_sym = rdata[EW-1:DUR_W];
   assign rd_dur = rdata[DUR_W-1:0];

   // A held event is written when it closes: symbol change, duration cap, or record end.
   always_comb begin
      wr_en = 1'b0;
      if (state == S_REC && dur != '0)
         wr_en = rec_fall || (tick && !extend);
   end

   // Address the next entry on the closing tick so PLAY_RD finds its data ready.
   always_comb begin
      raddr = rd_ptr[AW-1:0];
      if (state == S_IDLE)
         raddr = '0;
      else if (state == S_PLAY_RUN && tick && remaining == DUR_ONE)
         raddr = rd_nxt[AW-1:0];
   end

   rec_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (evt_count[AW-1:0]),
      .wdata ({held, dur}),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         held      <= '0;
         dur       <= '0;
         evt_count <= '0;
         full      <= 1'b0;
         rd_ptr    <= '0;
         remaining <= '0;
         key_out_r <= '0;
         oct_out_r <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (rec_rise) begin
                  state     <= S_REC;
                  evt_count <= '0;
                  full      <= 1'b0;
                  held      <= cur;
                  dur       <= '0;
               end else if (play_rise && !rec_s && evt_count != '0) begin
                  state  <= S_PLAY_RD;
                  rd_ptr <= '0;
               end
            end
            S_REC: begin
               if (rec_fall)
                  state <= S_IDLE;
               else if (tick) begin
                  if (extend) dur <= dur + DUR_ONE;
                  else begin
                     held <= cur;
                     dur  <= DUR_ONE;
                  end
               end
               if (wr_en) begin
                  evt_count <= evt_count + CNT_ONE;
                  if (evt_count == CNT_LAST) begin
                     full  <= 1'b1;
                     state <= S_IDLE;
                  end
               end
            end
            S_PLAY_RD: begin
               // Outputs keep the previous event until the new one is loaded.
               if (play_rise || rd_ptr == evt_count) begin
                  state     <= S_IDLE;
                  key_out_r <= '0;
                  oct_out_r <= '0;
               end else begin
                  key_out_r <= note_to_key(rd_sym.note);
                  oct_out_r <= rd_sym.oct;
                  remaining <= rd_dur;
                  state     <= S_PLAY_RUN;
               end
            end
            S_PLAY_RUN: begin
               if (play_rise) begin
                  state     <= S_IDLE;
                  key_out_r <= '0;
                  oct_out_r <= '0;
               end else if (tick) begin
                  remaining <= remaining - DUR_ONE;
                  if (remaining == DUR_ONE) begin
                     rd_ptr <= rd_nxt;
                     state  <= S_PLAY_RD;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.key_out   = key_out_r;
   assign bus.oct_out   = oct_out_r;
   assign bus.recording = (state == S_REC);
   assign bus.playing   = (state == S_PLAY_RD) || (state == S_PLAY_RUN);
   assign bus.full      = full;
   assign bus.evt_count = evt_count;

endmodule

// File: tb/tb_note_recorder.sv
// Directed + randomized bench for note_recorder; expected events come from a
// tick-level run-length model of the recorded performance.
module tb_note_recorder;

   localparam int TD   = 4;
   localparam int DP   = 4;
   localparam int DW   = 8;
   localparam int DMAX = (1 << DW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   note_recorder_if bus();

   note_recorder #(.TICK_DIV(TD), .DEPTH(DP), .DUR_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_on;

   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   typedef struct {
      logic [5:0] sym;
      int         dur;
   } ev_t;

   logic [6:0] kq[$];
   logic [2:0] oq[$];
   ev_t        evq[$];
   logic [5:0] pq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string t);
      check({t, "_key"}, bus.key_out, 0);
      check({t, "_oct"}, bus.oct_out, 0);
      check({t, "_rec"}, bus.recording, 0);
      check({t, "_play"}, bus.playing, 0);
      check({t, "_full"}, bus.full, 0);
      check({t, "_cnt"}, bus.evt_count, 0);
   endtask

   // note number from live keys: topmost pressed key is note 1
   function automatic logic [2:0] note_of(input logic [6:0] k);
      for (int b = 6; b >= 0; b--)
         if (k[b]) return 3'(7 - b);
      return 3'd0;
   endfunction

   function automatic logic [6:0] key_of(input logic [2:0] n);
      if (n == 3'd0) return 7'd0;
      return 7'b1 << (7 - int'(n));
   endfunction

   // run-length encode the symbols seen at the first n ticks, capped per event
   task automatic build(input int n);
      logic [5:0] s;
      int         last;
      evq.delete();
      for (int i = 0; i < n; i++) begin
         s    = {oq[i], note_of(kq[i])};
         last = evq.size() - 1;
         if (last >= 0 && evq[last].sym == s && evq[last].dur < DMAX)
            evq[last].dur = evq[last].dur + 1;
         else
            evq.push_back('{s, 1});
      end
   endtask

   // expected per-tick replay of the stored (possibly truncated) buffer
   task automatic expand();
      pq.delete();
      for (int e = 0; e < evq.size() && e < DP; e++)
         for (int d = 0; d < evq[e].dur; d++)
            pq.push_back(evq[e].sym);
   endtask

   task automatic align();
      do @(negedge clk); while (cyc % TD != 0);
   endtask

   task automatic record(input int n);
      align();
      bus.rec_sw = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.key_in = kq[i];
         bus.oct_in = oq[i];
         repeat (TD) @(negedge clk);
         build(i + 1);
         check("rec_state", bus.recording, (evq.size() - 1) < DP);
      end
      bus.rec_sw = 1'b0;
      bus.key_in = '0;
      bus.oct_in = '0;
      repeat (6) @(negedge clk);
      build(n);
      check("evt_count", bus.evt_count, (evq.size() < DP) ? evq.size() : DP);
      check("full", bus.full, evq.size() >= DP);
      check("rec_end", bus.recording, 0);
   endtask

   task automatic play(input bit toggle_rec);
      int on_cnt;
      int j;
      on_cnt = 0;
      expand();
      align();
      bus.play_btn = 1'b1;
      for (int c = 1; c <= 6 + TD * pq.size(); c++) begin
         @(negedge clk);
         if (bus.key_out != 7'd0) on_cnt++;
         if (c == 3) begin
            bus.play_btn = 1'b0;
            if (toggle_rec) bus.rec_sw = 1'b1;
         end
         if (c >= 6 && (c - 6) % TD == 0) begin
            j = (c - 6) / TD;
            if (j < pq.size()) begin
               check("play_key", bus.key_out, key_of(pq[j][2:0]));
               check("play_oct", bus.oct_out, pq[j][5:3]);
               check("playing", bus.playing, 1);
            end else begin
               check("play_done", bus.playing, 0);
               check("play_clr", {bus.key_out, bus.oct_out}, 0);
            end
         end
      end
      last_on = on_cnt;
   endtask

   task automatic load_seq(input logic [6:0] k, input logic [2:0] o, input int n);
      for (int i = 0; i < n; i++) begin
         kq.push_back(k);
         oq.push_back(o);
      end
   endtask

   initial begin
      logic [6:0] kp[3];
      logic [2:0] op[3];
      int         n, p;

      bus.rec_sw   = 1'b0;
      bus.play_btn = 1'b0;
      bus.key_in   = '0;
      bus.oct_in   = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // rest for 2 ticks, then note1/oct 010 for 3 ticks
      kq.delete(); oq.delete();
      load_seq(7'b0000000, 3'b000, 2);
      load_seq(7'b1000000, 3'b010, 3);
      record(5);
      check("s1_count", bus.evt_count, 2);
      play(1'b0);
      check("s2_on_clk", last_on, 12);

      // one key held past the duration cap splits into two events
      kq.delete(); oq.delete();
      load_seq(7'b0010000, 3'b101, 300);
      record(300);
      check("s3_count", bus.evt_count, 2);
      play(1'b0);

      // abort mid-event, then a fresh replay starts from the first event
      align();
      bus.play_btn = 1'b1;
      repeat (3) @(negedge clk);
      bus.play_btn = 1'b0;
      repeat (20) @(negedge clk);
      check("pre_abort_key", bus.key_out, key_of(pq[0][2:0]));
      bus.play_btn = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_key", bus.key_out, 0);
      check("abort_oct", bus.oct_out, 0);
      check("abort_play", bus.playing, 0);
      bus.play_btn = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_keep", bus.evt_count, 2);
      play(1'b0);

      // five distinct notes overflow a four-entry buffer
      kq.delete(); oq.delete();
      load_seq(7'b1000000, 3'b001, 1);
      load_seq(7'b0100000, 3'b001, 1);
      load_seq(7'b0010000, 3'b001, 1);
      load_seq(7'b0001000, 3'b001, 1);
      load_seq(7'b0000100, 3'b001, 1);
      record(5);
      check("s4_full", bus.full, 1);
      check("s4_count", bus.evt_count, 4);
      play(1'b0);

      // random performances drawn from a small symbol pool so runs repeat
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < 3; i++) begin
            kp[i] = 7'($urandom_range(0, 127));
            op[i] = 3'($urandom_range(0, 7));
         end
         kp[0] = 7'd0;
         kq.delete(); oq.delete();
         n = $urandom_range(1, 14);
         for (int i = 0; i < n; i++) begin
            p = $urandom_range(0, 2);
            kq.push_back(kp[p]);
            oq.push_back(op[p]);
         end
         record(n);
         play(it == 3);
      end

      // rec_sw rose during playback: no recording afterwards, play blocked while high
      check("rec_ignored", bus.recording, 0);
      bus.play_btn = 1'b1;
      repeat (6) @(negedge clk);
      check("play_blocked", bus.playing, 0);
      bus.play_btn = 1'b0;
      bus.rec_sw   = 1'b0;
      repeat (6) @(negedge clk);

      // reset while playing
      align();
      bus.play_btn = 1'b1;
      repeat (5) @(negedge clk);
      check("pre_rst_play", bus.playing, 1);
      rst = 1'b1;
      bus.play_btn = 1'b0;
      repeat (2) @(negedge clk);
      check_idle("rst_play");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      bus.play_btn = 1'b1;
      repeat (6) @(negedge clk);
      check("rst_play_ignored", bus.playing, 0);
      bus.play_btn = 1'b0;
      repeat (4) @(negedge clk);

      // reset while recording
      align();
      bus.rec_sw = 1'b1;
      bus.key_in = 7'b0000010;
      bus.oct_in = 3'b110;
      repeat (10) @(negedge clk);
      check("pre_rst_rec", bus.recording, 1);
      rst = 1'b1;
      bus.rec_sw = 1'b0;
      bus.key_in = '0;
      bus.oct_in = '0;
      repeat (2) @(negedge clk);
      check_idle("rst_rec");
      rst = 1'b0;
      repeat (3) @(negedge clk);
      bus.play_btn = 1'b1;
      repeat (6) @(negedge clk);
      check("rst_rec_ignored", bus.playing, 0);
      check("rst_rec_cnt", bus.evt_count, 0);
      bus.play_btn = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
